// File: rtl/thresh_debounce_if.sv
// Sample/threshold bus for the threshold debouncer: the driver presents samples
// and thresholds, the debouncer returns the alarm level, its edge pulses and status.
interface thresh_debounce_if #(
   parameter int N  = 8,
   parameter int CW = 4
);
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic [N-1:0]  thr_hi;
   logic [N-1:0]  thr_lo;
   logic          clr;
   logic          alarm;
   logic          alarm_rise;
   logic          alarm_fall;
   logic [CW-1:0] run_cnt;
   logic [N-1:0]  peak;

   modport master (
      output in_valid, in_data, thr_hi, thr_lo, clr,
      input  alarm, alarm_rise, alarm_fall, run_cnt, peak
   );

   modport slave (
      input  in_valid, in_data, thr_hi, thr_lo, clr,
      output alarm, alarm_rise, alarm_fall, run_cnt, peak
   );
endinterface

// File: rtl/thresh_debounce.sv
// Hysteretic threshold alarm: K consecutive samples beyond the active threshold
// toggle the alarm. Also tracks the peak valid sample since reset or clear.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_LOW  | alarm off; counting samples strictly above thr_hi
//   ST_HIGH | alarm on;  counting samples strictly below thr_lo
module thresh_debounce #(
   parameter int N  = 8,
   parameter int K  = 3,
   parameter int CW = 4
) (
   input  logic             clk,
   input  logic             rst,
   thresh_debounce_if.slave bus
);
   typedef enum logic {ST_LOW = 1'b0, ST_HIGH = 1'b1} state_t;

   localparam logic [2:0]    CMP_GT = 3'b100;
   localparam logic [2:0]    CMP_LT = 3'b001;
   localparam logic [CW-1:0] CNT_TC = CW'(K - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [N-1:0]  peak, peak_nxt;
   logic          rise, rise_nxt;
   logic          fall, fall_nxt;

   // {gt, eq, lt} of in_data against each threshold
   logic [2:0]    cmp_hi, cmp_lo;
   logic          qual;

   assign cmp_hi = {bus.in_data > bus.thr_hi, bus.in_data == bus.thr_hi, bus.in_data < bus.thr_hi};
   assign cmp_lo = {bus.in_data > bus.thr_lo, bus.in_data == bus.thr_lo, bus.in_data < bus.thr_lo};

   always_comb begin
      qual = 1'b0;
      if (bus.in_valid) begin
         if (state == ST_LOW) qual = (cmp_hi == CMP_GT);
         else                 qual = (cmp_lo == CMP_LT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         state <= ST_LOW;
         cnt   <= '0;
         peak  <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         peak  <= peak_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      peak_nxt  = peak;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (bus.in_valid) begin
         if (bus.in_data > peak) peak_nxt = bus.in_data;
         if (!qual) begin
            cnt_nxt = '0;
         end else if (cnt == CNT_TC) begin
            // terminal count: toggle and restart the run for the opposite direction
            cnt_nxt = '0;
            if (state == ST_LOW) begin
               state_nxt = ST_HIGH;
               rise_nxt  = 1'b1;
            end else begin
               state_nxt = ST_LOW;
               fall_nxt  = 1'b1;
            end
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   assign bus.alarm      = (state == ST_HIGH);
   assign bus.alarm_rise = rise;
   assign bus.alarm_fall = fall;
   assign bus.run_cnt    = cnt;
   assign bus.peak       = peak;
endmodule

// File: tb/tb_thresh_debounce.sv
// Directed-vector bench for thresh_debounce: a K=3 build and a K=1 build
// share clock and reset; each is stepped one sample per cycle.
module tb_thresh_debounce;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   thresh_debounce_if #(.N(8), .CW(4)) ifa ();
   thresh_debounce_if #(.N(8), .CW(4)) ifb ();

   thresh_debounce #(.N(8), .K(3), .CW(4)) u_k3 (.clk(clk), .rst(rst), .bus(ifa.slave));
   thresh_debounce #(.N(8), .K(1), .CW(4)) u_k1 (.clk(clk), .rst(rst), .bus(ifb.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic al, input logic ri, input logic fa,
                        input logic [3:0] cn, input logic [7:0] pk);
      chk({tag, ".alarm"}, 32'(ifa.alarm), 32'(al));
      chk({tag, ".rise"},  32'(ifa.alarm_rise), 32'(ri));
      chk({tag, ".fall"},  32'(ifa.alarm_fall), 32'(fa));
      chk({tag, ".cnt"},   32'(ifa.run_cnt), 32'(cn));
      chk({tag, ".peak"},  32'(ifa.peak), 32'(pk));
   endtask

   task automatic chk_b(input string tag, input logic al, input logic ri, input logic fa,
                        input logic [3:0] cn);
      chk({tag, ".alarm"}, 32'(ifb.alarm), 32'(al));
      chk({tag, ".rise"},  32'(ifb.alarm_rise), 32'(ri));
      chk({tag, ".fall"},  32'(ifb.alarm_fall), 32'(fa));
      chk({tag, ".cnt"},   32'(ifb.run_cnt), 32'(cn));
   endtask

   // one cycle on the K=3 build; the K=1 build sees no sample
   task automatic cyc_a(input logic v, input logic [7:0] d, input logic c = 1'b0);
      @(negedge clk);
      ifa.in_valid = v;
      ifa.in_data  = d;
      ifa.clr      = c;
      ifb.in_valid = 1'b0;
      @(posedge clk);
      #1;
      ifa.clr = 1'b0;
   endtask

   task automatic cyc_b(input logic v, input logic [7:0] d);
      @(negedge clk);
      ifb.in_valid = v;
      ifb.in_data  = d;
      ifa.in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.thr_hi = 8'd200; ifa.thr_lo = 8'd50; ifa.clr = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.thr_hi = 8'd200; ifb.thr_lo = 8'd50; ifb.clr = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_a("rst", 0, 0, 0, 0, 0);
      chk_b("rst_k1", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // three qualifying samples raise the alarm
      cyc_a(1, 201); chk_a("rise1", 0, 0, 0, 1, 201);
      cyc_a(1, 210); chk_a("rise2", 0, 0, 0, 2, 210);
      cyc_a(1, 255); chk_a("rise3", 1, 1, 0, 0, 255);
      cyc_a(0, 0);   chk_a("rise_end", 1, 0, 0, 0, 255);

      // falling run with invalid gaps holding the count
      cyc_a(1, 49);  chk_a("fall1", 1, 0, 0, 1, 255);
      for (int i = 0; i < 4; i++) begin
         cyc_a(0, 8'd0); chk_a("gap", 1, 0, 0, 1, 255);
      end
      cyc_a(1, 10);  chk_a("fall2", 1, 0, 0, 2, 255);
      cyc_a(1, 0);   chk_a("fall3", 0, 0, 1, 0, 255);
      cyc_a(0, 0);   chk_a("fall_end", 0, 0, 0, 0, 255);

      // equality with thr_hi breaks the run
      cyc_a(1, 201); chk_a("eq1", 0, 0, 0, 1, 255);
      cyc_a(1, 202); chk_a("eq2", 0, 0, 0, 2, 255);
      cyc_a(1, 200); chk_a("eq_hi", 0, 0, 0, 0, 255);
      cyc_a(1, 201); chk_a("eq3", 0, 0, 0, 1, 255);
      cyc_a(1, 205); chk_a("eq4", 0, 0, 0, 2, 255);
      cyc_a(1, 220); chk_a("eq5", 1, 1, 0, 0, 255);

      // equality with thr_lo breaks the run while HIGH
      cyc_a(1, 49);  chk_a("eqlo1", 1, 0, 0, 1, 255);
      cyc_a(1, 50);  chk_a("eq_lo", 1, 0, 0, 0, 255);
      cyc_a(1, 49);  chk_a("eqlo2", 1, 0, 0, 1, 255);
      cyc_a(1, 30);  chk_a("eqlo3", 1, 0, 0, 2, 255);

      // reset while HIGH overrides a qualifying sample and gives no fall pulse
      @(negedge clk);
      rst = 1'b1; ifa.in_valid = 1'b1; ifa.in_data = 8'd0;
      @(posedge clk); #1;
      chk_a("rst_high", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // clear mid-run, then first sample counts normally
      cyc_a(1, 201);    chk_a("clr1", 0, 0, 0, 1, 201);
      cyc_a(1, 202);    chk_a("clr2", 0, 0, 0, 2, 202);
      cyc_a(1, 250, 1); chk_a("clr", 0, 0, 0, 0, 0);
      cyc_a(1, 201);    chk_a("clr3", 0, 0, 0, 1, 201);

      // threshold change applies to the same cycle without clearing the run
      ifa.thr_hi = 8'd100;
      cyc_a(1, 150);    chk_a("thr1", 0, 0, 0, 2, 201);
      cyc_a(1, 150);    chk_a("thr2", 1, 1, 0, 0, 201);
      ifa.thr_hi = 8'd200;

      // K=1 build toggles on every qualifying sample
      cyc_b(1, 201); chk_b("k1_rise", 1, 1, 0, 0);
      cyc_b(0, 0);   chk_b("k1_hold", 1, 0, 0, 0);
      cyc_b(1, 50);  chk_b("k1_eqlo", 1, 0, 0, 0);
      cyc_b(1, 49);  chk_b("k1_fall", 0, 0, 1, 0);
      cyc_b(1, 200); chk_b("k1_eqhi", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
